rs_age_queue: RTL and testbench

//  Parametrised, unified reservation station for the R10K-style OoO core.

---
 rtl/rs_age_queue_if.sv | 36 +++
 rtl/rs_age_queue.sv | 130 +++++++++++++
 tb/tb_rs_age_queue.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rs_age_queue_if.sv
// Dispatch, CDB wakeup, flush and issue signals of the age-ordered reservation station.
// The slave modport belongs to the station; the master modport belongs to its driver.
interface rs_age_queue_if #(
    parameter int PREG_W    = 6,
    parameter int NUM_CDB   = 2,
    parameter int PAYLOAD_W = 64,
    parameter int IDX_W     = 3
) ();
    logic                      flush;
    logic                      disp_valid;
    logic                      disp_ready;
    logic [PREG_W-1:0]         disp_t1;
    logic [PREG_W-1:0]         disp_t2;
    logic                      disp_t1_rdy;
    logic                      disp_t2_rdy;
    logic [PAYLOAD_W-1:0]      disp_payload;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*PREG_W-1:0] cdb_tag;
    logic                      issue_valid;
    logic                      issue_ready;
    logic [PAYLOAD_W-1:0]      issue_payload;
    logic [IDX_W-1:0]          issue_idx;
    logic [IDX_W:0]            free_count;

    modport slave (
        input  flush, disp_valid, disp_t1, disp_t2, disp_t1_rdy, disp_t2_rdy, disp_payload,
        input  cdb_valid, cdb_tag, issue_ready,
        output disp_ready, issue_valid, issue_payload, issue_idx, free_count
    );

    modport master (
        output flush, disp_valid, disp_t1, disp_t2, disp_t1_rdy, disp_t2_rdy, disp_payload,
        output cdb_valid, cdb_tag, issue_ready,
        input  disp_ready, issue_valid, issue_payload, issue_idx, free_count
    );
endinterface

// File: rtl/rs_age_queue.sv
// Unified reservation station: CDB wakeup, oldest-ready issue via age matrix; issuable one cycle after
// dispatch or wakeup. issue_ready=0 holds entries in place; disp_ready drops only when every slot is occupied.
module rs_age_queue #(
    parameter int RS_DEPTH  = 8,
    parameter int PREG_W    = 6,
    parameter int NUM_CDB   = 2,
    parameter int PAYLOAD_W = 64,
    parameter int IDX_W     = $clog2(RS_DEPTH)
) (
    input  logic           clock,
    input  logic           reset,
    rs_age_queue_if.slave  io
);
    logic [RS_DEPTH-1:0]  valid_q, valid_d;
    logic [RS_DEPTH-1:0]  t1_rdy_q, t1_rdy_d;
    logic [RS_DEPTH-1:0]  t2_rdy_q, t2_rdy_d;
    logic [PREG_W-1:0]    t1_q [RS_DEPTH];
    logic [PREG_W-1:0]    t1_d [RS_DEPTH];
    logic [PREG_W-1:0]    t2_q [RS_DEPTH];
    logic [PREG_W-1:0]    t2_d [RS_DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [RS_DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [RS_DEPTH];
    // older_q[i][j] = 1 when entry i was allocated before entry j
    logic [RS_DEPTH-1:0]  older_q [RS_DEPTH];
    logic [RS_DEPTH-1:0]  older_d [RS_DEPTH];

    logic [RS_DEPTH-1:0]  eligible;
    logic [RS_DEPTH-1:0]  sel_oh;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     alloc_idx;
    logic                 alloc_found;
    logic [IDX_W:0]       occ;
    logic                 disp_t1_hit;
    logic                 disp_t2_hit;
    logic                 alloc_fire;
    logic                 issue_fire;

    always_comb begin
        eligible    = valid_q & t1_rdy_q & t2_rdy_q;
        sel_oh      = '0;
        sel_idx     = '0;
        alloc_idx   = '0;
        alloc_found = 1'b0;
        occ         = '0;
        disp_t1_hit = io.disp_t1_rdy || (io.disp_t1 == '0);
        disp_t2_hit = io.disp_t2_rdy || (io.disp_t2 == '0);
        for (int i = 0; i < RS_DEPTH; i++) begin
            sel_oh[i] = eligible[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (eligible[j] && older_q[j][i]) sel_oh[i] = 1'b0;
            end
            if (sel_oh[i]) sel_idx = IDX_W'(i);
            if (!valid_q[i] && !alloc_found) begin
                alloc_idx   = IDX_W'(i);
                alloc_found = 1'b1;
            end
            occ = occ + (IDX_W+1)'(valid_q[i]);
        end
        // Same-cycle CDB bypass into the entry being allocated
        for (int p = 0; p < NUM_CDB; p++) begin
            if (io.cdb_valid[p] && io.cdb_tag[p*PREG_W +: PREG_W] == io.disp_t1) disp_t1_hit = 1'b1;
            if (io.cdb_valid[p] && io.cdb_tag[p*PREG_W +: PREG_W] == io.disp_t2) disp_t2_hit = 1'b1;
        end
    end

    assign io.disp_ready    = alloc_found;
    assign io.free_count    = (IDX_W+1)'(RS_DEPTH) - occ;
    assign io.issue_valid   = |eligible;
    assign io.issue_idx     = sel_idx;
    assign io.issue_payload = payload_q[sel_idx];

    assign alloc_fire = io.disp_valid && alloc_found && !io.flush;
    assign issue_fire = (|eligible) && io.issue_ready && !io.flush;

    always_comb begin
        valid_d   = valid_q;
        t1_rdy_d  = t1_rdy_q;
        t2_rdy_d  = t2_rdy_q;
        t1_d      = t1_q;
        t2_d      = t2_q;
        payload_d = payload_q;
        older_d   = older_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int p = 0; p < NUM_CDB; p++) begin
                if (valid_q[i] && io.cdb_valid[p] && io.cdb_tag[p*PREG_W +: PREG_W] != '0) begin
                    if (io.cdb_tag[p*PREG_W +: PREG_W] == t1_q[i]) t1_rdy_d[i] = 1'b1;
                    if (io.cdb_tag[p*PREG_W +: PREG_W] == t2_q[i]) t2_rdy_d[i] = 1'b1;
                end
            end
        end
        if (alloc_fire) begin
            valid_d[alloc_idx]   = 1'b1;
            t1_d[alloc_idx]      = io.disp_t1;
            t2_d[alloc_idx]      = io.disp_t2;
            t1_rdy_d[alloc_idx]  = disp_t1_hit;
            t2_rdy_d[alloc_idx]  = disp_t2_hit;
            payload_d[alloc_idx] = io.disp_payload;
            older_d[alloc_idx]   = '0;
            for (int j = 0; j < RS_DEPTH; j++) older_d[j][alloc_idx] = valid_q[j];
        end
        // Issue clear runs after allocate so an entry leaving this cycle keeps no age bits
        if (issue_fire) begin
            valid_d[sel_idx] = 1'b0;
            older_d[sel_idx] = '0;
            for (int j = 0; j < RS_DEPTH; j++) older_d[j][sel_idx] = 1'b0;
        end
        if (io.flush) begin
            valid_d = '0;
            for (int i = 0; i < RS_DEPTH; i++) older_d[i] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            older_q <= older_d;
        end
    end

    always_ff @(posedge clock) begin
        t1_rdy_q  <= t1_rdy_d;
        t2_rdy_q  <= t2_rdy_d;
        t1_q      <= t1_d;
        t2_q      <= t2_d;
        payload_q <= payload_d;
    end
endmodule

// File: tb/tb_rs_age_queue.sv
module tb_rs_age_queue;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rs_age_queue_if #(.PREG_W(6), .NUM_CDB(2), .PAYLOAD_W(64), .IDX_W(3)) io ();

    rs_age_queue #(.RS_DEPTH(8), .PREG_W(6), .NUM_CDB(2), .PAYLOAD_W(64)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    typedef struct packed {
        logic [2:0]  idx;
        logic [63:0] pl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every accepted issue must match the head of the scoreboard
    always @(negedge clock) begin
        if (!reset && io.issue_valid && io.issue_ready && !io.flush) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got idx=%0d payload=%0h, required no issue", io.issue_idx, io.issue_payload);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (io.issue_idx !== e.idx || io.issue_payload !== e.pl) begin
                    errors++;
                    $display("FAIL issue_order: got idx=%0d payload=%0h, required idx=%0d payload=%0h",
                             io.issue_idx, io.issue_payload, e.idx, e.pl);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_issue(input logic [2:0] idx, input logic [63:0] pl);
        exp_t e;
        e.idx = idx;
        e.pl  = pl;
        sb.push_back(e);
    endtask

    task automatic dispatch(input logic [5:0] t1, input logic t1r, input logic [5:0] t2,
                            input logic t2r, input logic [63:0] pl);
        io.disp_valid   = 1'b1;
        io.disp_t1      = t1;
        io.disp_t1_rdy  = t1r;
        io.disp_t2      = t2;
        io.disp_t2_rdy  = t2r;
        io.disp_payload = pl;
        tick();
        io.disp_valid   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending issues, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset           = 1'b1;
        io.flush        = 1'b0;
        io.disp_valid   = 1'b0;
        io.disp_t1      = '0;
        io.disp_t2      = '0;
        io.disp_t1_rdy  = 1'b0;
        io.disp_t2_rdy  = 1'b0;
        io.disp_payload = '0;
        io.cdb_valid    = '0;
        io.cdb_tag      = '0;
        io.issue_ready  = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check("reset_disp_ready", 64'(io.disp_ready), 64'd1);
        check("reset_issue_valid", 64'(io.issue_valid), 64'd0);
        check("reset_free_count", 64'(io.free_count), 64'd8);

        // 1: three ready ops held, then released oldest first
        for (int k = 0; k < 3; k++) dispatch(6'd1, 1'b1, 6'd0, 1'b0, 64'h100 + 64'(k));
        check("t1_free_count_5", 64'(io.free_count), 64'd5);
        check("t1_head_idx", 64'(io.issue_idx), 64'd0);
        for (int k = 0; k < 3; k++) expect_issue(3'(k), 64'h100 + 64'(k));
        io.issue_ready = 1'b1;
        drain("t1");
        check("t1_free_count_8", 64'(io.free_count), 64'd8);

        // 2: fill with waiting ops, overflow dispatch ignored, single wakeup releases all
        for (int k = 0; k < 8; k++) dispatch(6'd5, 1'b0, 6'd0, 1'b0, 64'h200 + 64'(k));
        check("t2_disp_ready_full", 64'(io.disp_ready), 64'd0);
        check("t2_free_count_full", 64'(io.free_count), 64'd0);
        dispatch(6'd0, 1'b1, 6'd0, 1'b1, 64'hDEAD);
        check("t2_overflow_free_count", 64'(io.free_count), 64'd0);
        check("t2_overflow_no_issue", 64'(io.issue_valid), 64'd0);
        for (int k = 0; k < 8; k++) expect_issue(3'(k), 64'h200 + 64'(k));
        io.cdb_valid = 2'b01;
        io.cdb_tag   = {6'd0, 6'd5};
        check("t2_wake_not_same_cycle", 64'(io.issue_valid), 64'd0);
        tick();
        io.cdb_valid = 2'b00;
        check("t2_wake_issue_valid", 64'(io.issue_valid), 64'd1);
        check("t2_wake_issue_idx", 64'(io.issue_idx), 64'd0);
        drain("t2");
        check("t2_free_count_8", 64'(io.free_count), 64'd8);

        // 3: younger op in a lower slot must not overtake an older one
        expect_issue(3'd0, 64'h300);
        expect_issue(3'd1, 64'h301);
        expect_issue(3'd0, 64'h302);
        dispatch(6'd0, 1'b1, 6'd0, 1'b1, 64'h300);
        dispatch(6'd7, 1'b0, 6'd0, 1'b1, 64'h301);
        check("t3_waiting_no_issue", 64'(io.issue_valid), 64'd0);
        dispatch(6'd7, 1'b0, 6'd0, 1'b1, 64'h302);
        check("t3_free_count_6", 64'(io.free_count), 64'd6);
        io.cdb_valid = 2'b10;
        io.cdb_tag   = {6'd7, 6'd0};
        tick();
        io.cdb_valid = 2'b00;
        check("t3_oldest_selected", 64'(io.issue_idx), 64'd1);
        drain("t3");

        // 4: same-cycle bypass on CDB port 1
        expect_issue(3'd0, 64'h400);
        io.cdb_valid = 2'b10;
        io.cdb_tag   = {6'd9, 6'd0};
        dispatch(6'd0, 1'b0, 6'd9, 1'b0, 64'h400);
        io.cdb_valid = 2'b00;
        check("t4_bypass_issue_valid", 64'(io.issue_valid), 64'd1);
        drain("t4");

        // 5: stall holds entries and selection
        io.issue_ready = 1'b0;
        dispatch(6'd3, 1'b1, 6'd4, 1'b1, 64'h500);
        dispatch(6'd3, 1'b1, 6'd4, 1'b1, 64'h501);
        for (int k = 0; k < 4; k++) begin
            check("t5_stall_valid", 64'(io.issue_valid), 64'd1);
            check("t5_stall_idx", 64'(io.issue_idx), 64'd0);
            check("t5_stall_free_count", 64'(io.free_count), 64'd6);
            tick();
        end
        expect_issue(3'd0, 64'h500);
        expect_issue(3'd1, 64'h501);
        io.issue_ready = 1'b1;
        drain("t5");
        check("t5_free_count_8", 64'(io.free_count), 64'd8);

        // 6: flush drops everything including a simultaneous dispatch
        io.issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) dispatch(6'd0, 1'b1, 6'd0, 1'b1, 64'h600 + 64'(k));
        check("t6_free_count_3", 64'(io.free_count), 64'd3);
        io.flush = 1'b1;
        dispatch(6'd0, 1'b1, 6'd0, 1'b1, 64'h6FF);
        io.flush = 1'b0;
        check("t6_flush_free_count", 64'(io.free_count), 64'd8);
        check("t6_flush_issue_valid", 64'(io.issue_valid), 64'd0);
        check("t6_flush_disp_ready", 64'(io.disp_ready), 64'd1);
        io.issue_ready = 1'b1;
        repeat (3) tick();
        check("final_scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
